// File: rtl/btb_bht_predictor.sv
// ---------------------------------------------------------------------------
// btb_bht_predictor
//
// Direct-mapped branch target buffer for the baseline RISC-V core. Each
// entry carries a 2-bit saturating direction counter, so the BTB also acts
// as the branch history table. The fetch side looks up the IF-stage PC
// combinationally. The resolve side compares the actual outcome with the
// prediction that travelled down the pipeline, raises flush/redirect on any
// mismatch, and updates the table one cycle after it captures the outcome.
// Saturating performance counters record branches and mispredicts.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous reset, active-high
//   memory_stall     pipeline frozen; held resolve inputs are not recaptured
//   fetch_pc         IF-stage PC to predict
//   pred_hit         valid entry with matching tag for fetch_pc
//   pred_taken       predicted taken
//   pred_target      predicted next PC
//   res_valid        resolve slot holds a valid instruction
//   res_is_branch    resolving instruction is a branch or jump
//   res_pc           PC of the resolving instruction
//   res_taken        actual direction
//   res_target       actual target (word aligned)
//   res_pred_taken   pred_taken carried with this instruction
//   res_pred_target  pred_target carried with this instruction
//   flush            mispredict; squash younger instructions
//   redirect_pc      correct next PC, meaningful when flush=1
//   perf_branches    count of captured branches
//   perf_mispredicts count of captured mispredicts
// ---------------------------------------------------------------------------
module btb_bht_predictor #(
   parameter int PC_W    = 32,
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memory_stall,
   input  logic [PC_W-1:0]  fetch_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pred_target,
   input  logic             res_valid,
   input  logic             res_is_branch,
   input  logic [PC_W-1:0]  res_pc,
   input  logic             res_taken,
   input  logic [PC_W-1:0]  res_target,
   input  logic             res_pred_taken,
   input  logic [PC_W-1:0]  res_pred_target,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_mispredicts
);

   localparam int TGT_W = PC_W - 2;

   // Table storage, one slot per index. Targets are stored as word
   // addresses since every branch target is word aligned.
   logic             entry_valid  [ENTRIES];
   logic [TAG_W-1:0] entry_tag    [ENTRIES];
   logic [TGT_W-1:0] entry_target [ENTRIES];
   logic [1:0]       entry_ctr    [ENTRIES];

   logic [IDX_W-1:0] fetch_idx;
   logic [TAG_W-1:0] fetch_tag;
   logic             mp;
   logic             capture;

   // Outcome captured at the resolve edge, written into the table at the
   // following edge.
   logic             upd_v;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_taken;
   logic [TGT_W-1:0] upd_target;
   logic             upd_mp;
   logic             upd_hit;

   assign fetch_idx = fetch_pc[IDX_W+1:2];
   assign fetch_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];

   // Fetch-side lookup. There is deliberately no bypass from the pending
   // write: a lookup to the index being written this cycle sees the old
   // entry, and the new contents show up one cycle later.
   always_comb begin
      pred_hit    = entry_valid[fetch_idx] && (entry_tag[fetch_idx] == fetch_tag);
      pred_taken  = pred_hit && entry_ctr[fetch_idx][1];
      pred_target = fetch_pc + PC_W'(4);
      if (pred_taken) begin
         pred_target = {entry_target[fetch_idx], 2'b00};
      end
   end

   // Mispredict detection. A wrong direction always mispredicts; a correct
   // taken prediction still mispredicts when the carried target is stale.
   // Flush does not wait for a stall to clear so the front end squashes the
   // wrong path as early as possible.
   assign mp = res_valid && res_is_branch &&
               ((res_taken != res_pred_taken) ||
                (res_taken && (res_target != res_pred_target)));

   assign flush       = mp;
   assign redirect_pc = (mp && res_taken) ? res_target : res_pc + PC_W'(4);

   // A frozen pipeline keeps the same branch on the resolve inputs for
   // several cycles, so only an unstalled cycle captures it. That way each
   // branch is counted and trained exactly once.
   assign capture = res_valid && res_is_branch && !memory_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         upd_v      <= 1'b0;
         upd_idx    <= '0;
         upd_tag    <= '0;
         upd_taken  <= 1'b0;
         upd_target <= '0;
         upd_mp     <= 1'b0;
      end else begin
         upd_v <= capture;
         if (capture) begin
            upd_idx    <= res_pc[IDX_W+1:2];
            upd_tag    <= res_pc[IDX_W+TAG_W+1:IDX_W+2];
            upd_taken  <= res_taken;
            upd_target <= res_target[PC_W-1:2];
            upd_mp     <= mp;
         end
      end
   end

   // Hit/miss for training is judged against the table as it stands at the
   // write edge, which may differ from what the fetch side saw earlier.
   assign upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

   // Table write. Hits train the counter (and refresh the target when
   // taken); a taken miss allocates over whatever occupied the slot, starting
   // weakly taken; a not-taken miss leaves the table alone. Reset wins over
   // any pending update, and counters come out of reset weakly not-taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_valid[i]  <= 1'b0;
            entry_tag[i]    <= '0;
            entry_target[i] <= '0;
            entry_ctr[i]    <= 2'b01;
         end
      end else if (upd_v) begin
         if (upd_hit) begin
            if (upd_taken) begin
               entry_target[upd_idx] <= upd_target;
               if (entry_ctr[upd_idx] != 2'b11) begin
                  entry_ctr[upd_idx] <= entry_ctr[upd_idx] + 2'b01;
               end
            end else if (entry_ctr[upd_idx] != 2'b00) begin
               entry_ctr[upd_idx] <= entry_ctr[upd_idx] - 2'b01;
            end
         end else if (upd_taken) begin
            entry_valid[upd_idx]  <= 1'b1;
            entry_tag[upd_idx]    <= upd_tag;
            entry_target[upd_idx] <= upd_target;
            entry_ctr[upd_idx]    <= 2'b10;
         end
      end
   end

   // Performance counters advance together with the table write so they
   // reflect trained branches only, and they stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else if (upd_v) begin
         if (perf_branches != '1) begin
            perf_branches <= perf_branches + CNT_W'(1);
         end
         if (upd_mp && (perf_mispredicts != '1)) begin
            perf_mispredicts <= perf_mispredicts + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_btb_bht_predictor.sv
// ---------------------------------------------------------------------------
// tb_btb_bht_predictor
//
// Self-checking bench for btb_bht_predictor with default parameters
// (32-bit PC, 16 entries, 4-bit tags, 16-bit counters). Inputs change just
// after the falling edge and outputs are compared 1 time unit later.
// ---------------------------------------------------------------------------
module tb_btb_bht_predictor;

   localparam int ENTRIES = 16;
   localparam int IDX_W   = 4;
   localparam int TAG_W   = 4;

   logic        clk;
   logic        rst;
   logic        memory_stall;
   logic [31:0] fetch_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid;
   logic        res_is_branch;
   logic [31:0] res_pc;
   logic        res_taken;
   logic [31:0] res_target;
   logic        res_pred_taken;
   logic [31:0] res_pred_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [15:0] perf_branches;
   logic [15:0] perf_mispredicts;

   int passed;
   int total;

   btb_bht_predictor dut (
      .clk              (clk),
      .rst              (rst),
      .memory_stall     (memory_stall),
      .fetch_pc         (fetch_pc),
      .pred_hit         (pred_hit),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .res_valid        (res_valid),
      .res_is_branch    (res_is_branch),
      .res_pc           (res_pc),
      .res_taken        (res_taken),
      .res_target       (res_target),
      .res_pred_taken   (res_pred_taken),
      .res_pred_target  (res_pred_target),
      .flush            (flush),
      .redirect_pc      (redirect_pc),
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: what the table should hold, plus the branch
   // waiting to be trained and the expected counter values.
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   bit          p_v;
   logic [31:0] p_pc;
   bit          p_taken;
   logic [31:0] p_target;
   bit          p_mp;
   int unsigned m_branches;
   int unsigned m_mispredicts;

   typedef struct {
      logic        rv;
      logic        rb;
      logic [31:0] rpc;
      logic        rt;
      logic [31:0] rtg;
      logic        rpt;
      logic [31:0] rptg;
      logic [31:0] fpc;
      logic        e_flush;
      logic [31:0] e_redirect;
      logic [31:0] e_target;
   } vec_t;

   vec_t vecs [9];

   // One comparison; counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic checkPred(input string name, input logic hit, input logic tkn, input logic [31:0] tgt);
      checkOutput({name, ".hit"}, {31'd0, pred_hit}, {31'd0, hit});
      checkOutput({name, ".taken"}, {31'd0, pred_taken}, {31'd0, tkn});
      checkOutput({name, ".target"}, pred_target, tgt);
   endtask

   task automatic checkPerf(input string name, input int unsigned br, input int unsigned mp);
      checkOutput({name, ".branches"}, {16'd0, perf_branches}, br);
      checkOutput({name, ".mispredicts"}, {16'd0, perf_mispredicts}, mp);
   endtask

   task automatic applyStimulus(input logic rv, input logic rb, input logic [31:0] pc,
                                input logic tkn, input logic [31:0] tgt,
                                input logic ptkn, input logic [31:0] ptgt);
      res_valid       = rv;
      res_is_branch   = rb;
      res_pc          = pc;
      res_taken       = tkn;
      res_target      = tgt;
      res_pred_taken  = ptkn;
      res_pred_target = ptgt;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Advance one clock and settle just past the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Resolve one branch, check the same-cycle flush, then idle through the
   // capture and write edges.
   task automatic resolveAndTrain(input string name, input logic [31:0] pc, input logic tkn,
                                  input logic [31:0] tgt, input logic ptkn, input logic [31:0] ptgt,
                                  input logic e_flush, input logic [31:0] e_redir);
      applyStimulus(1'b1, 1'b1, pc, tkn, tgt, ptkn, ptgt);
      #1;
      checkOutput({name, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
      if (e_flush) checkOutput({name, ".redirect"}, redirect_pc, e_redir);
      tick();
      idle();
      tick();
      #1;
   endtask

   // ---- reference model ----
   function automatic int unsigned idxOf(input logic [31:0] pc);
      return (pc >> 2) % ENTRIES;
   endfunction

   function automatic int unsigned tagOf(input logic [31:0] pc);
      return (pc >> (2 + IDX_W)) % (1 << TAG_W);
   endfunction

   function automatic bit expMp();
      if (!(res_valid && res_is_branch)) return 1'b0;
      if (res_taken != res_pred_taken) return 1'b1;
      return res_taken && (res_target != res_pred_target);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_target[i] = 32'h0;
         m_ctr[i]    = 1;
      end
      p_v           = 1'b0;
      m_branches    = 0;
      m_mispredicts = 0;
   endtask

   // What happens at the coming rising edge, given the current inputs:
   // the pending branch trains the table, and the current one is captured.
   task automatic modelEdge();
      bit          n_v;
      bit          hit;
      int unsigned ix;
      n_v = res_valid && res_is_branch && !memory_stall;
      if (rst) begin
         modelReset();
         return;
      end
      if (p_v) begin
         ix  = idxOf(p_pc);
         hit = m_valid[ix] && (m_tag[ix] == tagOf(p_pc));
         if (hit && p_taken) begin
            m_ctr[ix]    = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
            m_target[ix] = p_target & 32'hFFFF_FFFC;
         end else if (hit) begin
            m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
         end else if (p_taken) begin
            m_valid[ix]  = 1'b1;
            m_tag[ix]    = tagOf(p_pc);
            m_target[ix] = p_target & 32'hFFFF_FFFC;
            m_ctr[ix]    = 2;
         end
         if (m_branches < 65535) m_branches++;
         if (p_mp && m_mispredicts < 65535) m_mispredicts++;
      end
      if (n_v) begin
         p_pc     = res_pc;
         p_taken  = res_taken;
         p_target = res_target;
         p_mp     = expMp();
      end
      p_v = n_v;
   endtask

   task automatic checkAgainstModel();
      int unsigned ix;
      bit          hit;
      bit          tkn;
      logic [31:0] tgt;
      bit          mp;
      ix  = idxOf(fetch_pc);
      hit = m_valid[ix] && (m_tag[ix] == tagOf(fetch_pc));
      tkn = hit && (m_ctr[ix] >= 2);
      tgt = tkn ? m_target[ix] : fetch_pc + 32'd4;
      mp  = expMp();
      checkPred("rand", hit, tkn, tgt);
      checkOutput("rand.flush", {31'd0, flush}, {31'd0, mp});
      checkOutput("rand.redirect", redirect_pc, (mp && res_taken) ? res_target : res_pc + 32'd4);
      checkPerf("rand", m_branches, m_mispredicts);
   endtask

   function automatic logic [31:0] randPc();
      logic [31:0] v;
      if ($urandom_range(0, 15) == 0) begin
         v = $urandom();
         return v & 32'hFFFF_FFFC;
      end
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   initial begin
      passed = 0;
      total  = 0;

      // Resolve-side vectors applied under a stall with an empty table, so
      // nothing is captured and only the combinational paths are exercised.
      vecs[0] = '{1, 1, 32'h100, 1, 32'h200, 1, 32'h200, 32'h10,       0, 32'h104, 32'h14};
      vecs[1] = '{1, 1, 32'h100, 1, 32'h200, 1, 32'h300, 32'hFFFFFFFC, 1, 32'h200, 32'h0};
      vecs[2] = '{1, 1, 32'h100, 0, 32'h200, 0, 32'h300, 32'h7FFFFFFC, 0, 32'h104, 32'h80000000};
      vecs[3] = '{1, 1, 32'h100, 0, 32'h200, 1, 32'h200, 32'h40,       1, 32'h104, 32'h44};
      vecs[4] = '{1, 1, 32'h100, 1, 32'h500, 0, 32'h104, 32'h1234,     1, 32'h500, 32'h1238};
      vecs[5] = '{0, 1, 32'h100, 1, 32'h500, 0, 32'h104, 32'h0,        0, 32'h104, 32'h4};
      vecs[6] = '{1, 0, 32'h100, 1, 32'h500, 0, 32'h104, 32'h8,        0, 32'h104, 32'hC};
      vecs[7] = '{1, 1, 32'hFFFFFFFC, 0, 32'h8, 1, 32'h8, 32'h20,      1, 32'h0, 32'h24};
      vecs[8] = '{0, 1, 32'hFFFFFFFC, 1, 32'h8, 0, 32'h8, 32'h24,      0, 32'h0, 32'h28};

      rst          = 1'b1;
      memory_stall = 1'b0;
      fetch_pc     = 32'h40;
      idle();
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkPred("reset", 1'b0, 1'b0, 32'h44);
      checkPerf("reset", 0, 0);

      memory_stall = 1'b1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].rv, vecs[i].rb, vecs[i].rpc, vecs[i].rt, vecs[i].rtg,
                       vecs[i].rpt, vecs[i].rptg);
         fetch_pc = vecs[i].fpc;
         #1;
         checkOutput($sformatf("vec%0d.flush", i), {31'd0, flush}, {31'd0, vecs[i].e_flush});
         checkOutput($sformatf("vec%0d.redirect", i), redirect_pc, vecs[i].e_redirect);
         checkPred($sformatf("vec%0d", i), 1'b0, 1'b0, vecs[i].e_target);
         tick();
      end
      checkPerf("vec.stalled", 0, 0);
      idle();
      memory_stall = 1'b0;
      tick();

      // Allocation by a taken miss.
      fetch_pc = 32'h40;
      resolveAndTrain("alloc", 32'h40, 1, 32'h80, 0, 32'h44, 1, 32'h80);
      checkPred("alloc", 1'b1, 1'b1, 32'h80);
      checkPerf("alloc", 1, 1);

      // Train down 2 -> 1 -> 0.
      resolveAndTrain("nt1", 32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h44);
      checkPred("nt1", 1'b1, 1'b0, 32'h44);
      resolveAndTrain("nt2", 32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h44);
      checkPred("nt2", 1'b1, 1'b0, 32'h44);

      // Train up 0 -> 1 -> 2 -> 3, then one more taken must stay at 3.
      resolveAndTrain("t1", 32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h0);
      checkPred("t1", 1'b1, 1'b0, 32'h44);
      resolveAndTrain("t2", 32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h0);
      checkPred("t2", 1'b1, 1'b1, 32'h80);
      resolveAndTrain("t3", 32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h0);
      resolveAndTrain("t4", 32'h40, 1, 32'h80, 1, 32'h80, 0, 32'h0);
      resolveAndTrain("sat", 32'h40, 0, 32'h80, 1, 32'h80, 1, 32'h44);
      checkPred("sat", 1'b1, 1'b1, 32'h80);
      checkPerf("sat", 8, 4);

      // Right direction, stale target: counter 2 -> 3 and target replaced.
      resolveAndTrain("tgt", 32'h40, 1, 32'hC0, 1, 32'h80, 1, 32'hC0);
      checkPred("tgt", 1'b1, 1'b1, 32'hC0);
      resolveAndTrain("tgt.nt", 32'h40, 0, 32'hC0, 1, 32'hC0, 1, 32'h44);
      checkPred("tgt.nt", 1'b1, 1'b1, 32'hC0);
      checkPerf("tgt", 10, 6);

      // Alias on index 0 evicts 0x40; the write cycle still shows the old entry.
      applyStimulus(1'b1, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
      #1;
      checkOutput("evict.flush", {31'd0, flush}, 32'd1);
      checkOutput("evict.redirect", redirect_pc, 32'h100);
      tick();
      idle();
      fetch_pc = 32'h40;
      #1;
      checkPred("evict.writecycle", 1'b1, 1'b1, 32'hC0);
      tick();
      #1;
      checkPred("evict.old", 1'b0, 1'b0, 32'h44);
      fetch_pc = 32'h80;
      #1;
      checkPred("evict.new", 1'b1, 1'b1, 32'h100);
      checkPerf("evict", 11, 7);

      // Stall for 3 cycles with the branch held; exactly one capture follows.
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
      memory_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("stall%0d.flush", i), {31'd0, flush}, 32'd1);
         tick();
      end
      memory_stall = 1'b0;
      #1;
      checkOutput("stall.release.flush", {31'd0, flush}, 32'd1);
      checkPerf("stall.release", 11, 7);
      tick();
      idle();
      tick();
      fetch_pc = 32'h200;
      #1;
      checkPerf("stall.once", 12, 8);
      checkPred("stall.entry", 1'b1, 1'b1, 32'h300);

      // Reset on the write edge of a pending update drops it.
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      fetch_pc = 32'h40;
      #1;
      checkPred("rstdrop.40", 1'b0, 1'b0, 32'h44);
      checkPerf("rstdrop", 0, 0);
      fetch_pc = 32'h200;
      #1;
      checkPred("rstdrop.200", 1'b0, 1'b0, 32'h204);

      // Randomized traffic against the reference model, from a clean reset.
      rst = 1'b1;
      idle();
      modelEdge();
      tick();
      rst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [31:0] tg;
         logic [31:0] pt;
         rst          = ($urandom_range(0, 199) == 0);
         memory_stall = ($urandom_range(0, 4) == 0);
         fetch_pc     = randPc();
         tg           = randPc();
         pt           = ($urandom_range(0, 2) == 0) ? randPc() : tg;
         applyStimulus($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, randPc(),
                       1'($urandom_range(0, 1)), tg, 1'($urandom_range(0, 1)), pt);
         #1;
         checkAgainstModel();
         modelEdge();
         tick();
      end

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
